// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-phase FSM and program-counter datapath.
// Steps through FETCH/DECODE/EXECUTE/COMMIT and drives the memory read
// handshake. A wait counter aborts a read that stalls too long. The next PC
// is computed at COMMIT from the jump-group selections.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned WAIT_MAX     = 15
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [1:0]  PC_BASEX,
    input  logic [1:0]  PC_OFFSETX,
    input  logic [1:0]  ADDR_BUSX,
    input  logic        RDX,
    input  logic [15:0] REGB_DOUT,
    input  logic [15:0] DIN,
    input  logic        MEM_READY,
    output logic        FETCH,
    output logic        DECODE,
    output logic        EXECUTE,
    output logic        COMMIT,
    output logic [15:0] PC,
    output logic [15:0] HERE,
    output logic [15:0] ADDR,
    output logic        RD,
    output logic [15:0] INSTR,
    output logic [15:0] DIN_REG,
    output logic        BUS_ERROR
);

    localparam logic [1:0] PC_BASEX_0         = 2'd0;
    localparam logic [1:0] PC_BASEX_PC_A      = 2'd1;
    localparam logic [1:0] PC_BASEX_REGB_DOUT = 2'd2;

    localparam logic [1:0] PC_OFFSETX_0   = 2'd0;
    localparam logic [1:0] PC_OFFSETX_2   = 2'd1;
    localparam logic [1:0] PC_OFFSETX_4   = 2'd2;
    localparam logic [1:0] PC_OFFSETX_DIN = 2'd3;

    localparam logic [1:0] ADDR_BUSX_PC_A = 2'd0;
    localparam logic [1:0] ADDR_BUSX_HERE = 2'd1;

    localparam logic [7:0]  WAIT_LIM = 8'(WAIT_MAX);
    localparam logic [15:0] PC_RESET = {RESET_VECTOR[15:1], 1'b0};

    typedef enum logic [2:0] {
        ST_RST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q;
    logic [15:0] din_reg_q;
    logic        bus_err_q;
    logic        abort;
    logic        rd;
    logic [15:0] here;
    logic [15:0] base;
    logic [15:0] offset;
    logic [15:0] sum;

    assign here = pc_q + 16'd2;

    // Phase state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_RST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase; a stalled read at the wait limit aborts back to FETCH.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            ST_RST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (MEM_READY) begin
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LIM) begin
                    abort = 1'b1;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (!RDX || MEM_READY) begin
                    state_d = ST_COMMIT;
                end else if (wait_q == WAIT_LIM) begin
                    abort   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_COMMIT: state_d = ST_FETCH;
            default:   state_d = ST_RST_IDLE;
        endcase
    end

    // Phase strobes and memory bus decoded from the registered phase.
    always_comb begin
        FETCH   = (state_q == ST_FETCH);
        DECODE  = (state_q == ST_DECODE);
        EXECUTE = (state_q == ST_EXECUTE);
        COMMIT  = (state_q == ST_COMMIT);
        rd      = 1'b0;
        ADDR    = pc_q;
        if (state_q == ST_FETCH) begin
            rd = 1'b1;
        end else if (state_q == ST_EXECUTE && RDX) begin
            rd = 1'b1;
            if (ADDR_BUSX == ADDR_BUSX_HERE) begin
                ADDR = here;
            end else if (ADDR_BUSX == ADDR_BUSX_PC_A) begin
                ADDR = pc_q;
            end
        end
    end

    // Wait counter: counts stalled read cycles, cleared on any phase change or abort.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q || abort) begin
            wait_d = '0;
        end else if (rd && !MEM_READY) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // Next PC: base plus offset, wrapped to 16 bits and halfword aligned.
    always_comb begin
        base = pc_q;
        case (PC_BASEX)
            PC_BASEX_0:         base = '0;
            PC_BASEX_PC_A:      base = pc_q;
            PC_BASEX_REGB_DOUT: base = REGB_DOUT;
            default:            base = pc_q;
        endcase
        offset = '0;
        case (PC_OFFSETX)
            PC_OFFSETX_0:   offset = '0;
            PC_OFFSETX_2:   offset = 16'd2;
            PC_OFFSETX_4:   offset = 16'd4;
            PC_OFFSETX_DIN: offset = din_reg_q;
            default:        offset = '0;
        endcase
        sum  = base + offset;
        pc_d = {sum[15:1], 1'b0};
    end

    // Datapath registers: instruction/operand latches, PC, wait count, error pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q      <= PC_RESET;
            instr_q   <= '0;
            din_reg_q <= '0;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            bus_err_q <= abort;
            if (state_q == ST_FETCH && MEM_READY) begin
                instr_q <= DIN;
            end
            if (state_q == ST_EXECUTE && RDX && MEM_READY) begin
                din_reg_q <= DIN;
            end
            if (state_q == ST_COMMIT) begin
                pc_q <= pc_d;
            end
        end
    end

    assign PC        = pc_q;
    assign HERE      = here;
    assign RD        = rd;
    assign INSTR     = instr_q;
    assign DIN_REG   = din_reg_q;
    assign BUS_ERROR = bus_err_q;

endmodule
